// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase encoding,
// default durations, counter width and a small helper function.
package traffic_pkg;

  localparam int CNT_W          = 6;
  localparam int GREEN_MIN_DEF  = 10;
  localparam int GREEN_MAX_DEF  = 30;
  localparam int YELLOW_LEN_DEF = 5;
  localparam int ALLRED_LEN_DEF = 2;
  localparam int WALK_LEN_DEF   = 7;

  // Phase codes; PH_ILL is never entered deliberately and is recovered from.
  typedef enum logic [2:0] {
    PH_NS_G = 3'd0,
    PH_NS_Y = 3'd1,
    PH_AR1  = 3'd2,
    PH_EW_G = 3'd3,
    PH_EW_Y = 3'd4,
    PH_AR2  = 3'd5,
    PH_PRE  = 3'd6,
    PH_ILL  = 3'd7
  } phase_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: synchronous clear, saturating increment on tick,
// and an expire flag raised on the tick where cnt has reached len-1.
module phase_timer
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear wins, otherwise saturating increment on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign expire = tick && (cnt_q >= (len - 1'b1));

endmodule

// File: rtl/intersection_ctrl.sv
// Two-head intersection controller (NS / EW) with demand-driven green
// arbitration, latched pedestrian requests and emergency preemption.
// Optional pedestrian walk outputs: define INTERSECTION_PED_WALK_EN.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = GREEN_MIN_DEF,
  parameter int GREEN_MAX  = GREEN_MAX_DEF,
  parameter int YELLOW_LEN = YELLOW_LEN_DEF,
  parameter int ALLRED_LEN = ALLRED_LEN_DEF,
  parameter int WALK_LEN   = WALK_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       preempt,
  output logic       R_ns,
  output logic       Y_ns,
  output logic       G_ns,
  output logic       R_ew,
  output logic       Y_ew,
  output logic       G_ew,
`ifdef INTERSECTION_PED_WALK_EN
  output logic       walk_ns,
  output logic       walk_ew,
`endif
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] LEN_GMIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] LEN_Y    = CNT_W'(YELLOW_LEN);
  localparam logic [CNT_W-1:0] LEN_AR   = CNT_W'(ALLRED_LEN);
  localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(GREEN_MAX - 1);

  // Every duration must be at least one tick for the len-1 compare to hold.
  if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_LEN < 1 ||
      ALLRED_LEN < 1 || WALK_LEN < 1) begin : g_bad_params
    $error("intersection_ctrl: illegal duration parameters");
  end

  phase_t           phase_d, phase_q;
  logic             ped_ns_lat_d, ped_ns_lat_q;
  logic             ped_ew_lat_d, ped_ew_lat_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             expire;
  logic             phase_chg;
  logic             dem_ns, dem_ew;
  logic             ns_go, ew_go;
  logic             enter_ns, enter_ew;
  logic [CNT_W-1:0] len_green_ns, len_green_ew;

  assign dem_ns    = car_ns | ped_ns_lat_q;
  assign dem_ew    = car_ew | ped_ew_lat_q;
  assign phase_chg = (phase_d != phase_q);
  assign enter_ns  = (phase_d == PH_NS_G) && (phase_q != PH_NS_G);
  assign enter_ew  = (phase_d == PH_EW_G) && (phase_q != PH_EW_G);

`ifdef INTERSECTION_PED_WALK_EN
  localparam logic [CNT_W-1:0] LEN_GWALK = CNT_W'(imax(GREEN_MIN, WALK_LEN + 3));
  localparam logic [CNT_W-1:0] WALK_CNT  = CNT_W'(WALK_LEN);

  logic walk_srv_ns_d, walk_srv_ns_q;
  logic walk_srv_ew_d, walk_srv_ew_q;

  // A served walk is remembered for the whole green it was granted in.
  always_comb begin
    walk_srv_ns_d = 1'b0;
    walk_srv_ew_d = 1'b0;
    if (phase_d == PH_NS_G) walk_srv_ns_d = enter_ns ? ped_ns_lat_q : walk_srv_ns_q;
    if (phase_d == PH_EW_G) walk_srv_ew_d = enter_ew ? ped_ew_lat_q : walk_srv_ew_q;
  end

  // Walk-served flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      walk_srv_ns_q <= 1'b0;
      walk_srv_ew_q <= 1'b0;
    end else begin
      walk_srv_ns_q <= walk_srv_ns_d;
      walk_srv_ew_q <= walk_srv_ew_d;
    end
  end

  assign walk_ns      = (phase_q == PH_NS_G) && walk_srv_ns_q && (cnt < WALK_CNT);
  assign walk_ew      = (phase_q == PH_EW_G) && walk_srv_ew_q && (cnt < WALK_CNT);
  assign len_green_ns = walk_srv_ns_q ? LEN_GWALK : LEN_GMIN;
  assign len_green_ew = walk_srv_ew_q ? LEN_GWALK : LEN_GMIN;
`else
  assign len_green_ns = LEN_GMIN;
  assign len_green_ew = LEN_GMIN;
`endif

  // Select the duration the timer compares against for the current phase.
  always_comb begin
    len = LEN_AR;
    case (phase_q)
      PH_NS_G:          len = len_green_ns;
      PH_EW_G:          len = len_green_ew;
      PH_NS_Y, PH_EW_Y: len = LEN_Y;
      default:          len = LEN_AR;
    endcase
  end

  phase_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .clr    (phase_chg),
    .len    (len),
    .cnt    (cnt),
    .expire (expire)
  );

  // Green yields only with opposing demand, once the minimum (or maximum) is met.
  assign ns_go = dem_ew && (expire || (tick && (cnt >= GMAX_M1) && (cnt >= len - 1'b1)));
  assign ew_go = dem_ns && (expire || (tick && (cnt >= GMAX_M1) && (cnt >= len - 1'b1)));

  // Next-phase logic; preemption is checked every clock ahead of tick timing.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_NS_G: if (preempt || ns_go) phase_d = PH_NS_Y;
      PH_EW_G: if (preempt || ew_go) phase_d = PH_EW_Y;
      PH_NS_Y: if (expire) phase_d = preempt ? PH_PRE : PH_AR1;
      PH_EW_Y: if (expire) phase_d = preempt ? PH_PRE : PH_AR2;
      PH_AR1:  if (preempt) phase_d = PH_PRE;
               else if (expire) phase_d = PH_EW_G;
      PH_AR2:  if (preempt) phase_d = PH_PRE;
               else if (expire) phase_d = PH_NS_G;
      PH_PRE:  if (!preempt) phase_d = PH_AR2;
      default: phase_d = PH_AR2;
    endcase
  end

  // Pedestrian latches: a new request beats the clear on green entry.
  always_comb begin
    ped_ns_lat_d = ped_ns | (ped_ns_lat_q & ~enter_ns);
    ped_ew_lat_d = ped_ew | (ped_ew_lat_q & ~enter_ew);
  end

  // Phase and latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_NS_G;
      ped_ns_lat_q <= 1'b0;
      ped_ew_lat_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      ped_ns_lat_q <= ped_ns_lat_d;
      ped_ew_lat_q <= ped_ew_lat_d;
    end
  end

  // Lamp decode: exactly one lamp per head, red on anything not explicitly go.
  always_comb begin
    R_ns = 1'b1; Y_ns = 1'b0; G_ns = 1'b0;
    R_ew = 1'b1; Y_ew = 1'b0; G_ew = 1'b0;
    case (phase_q)
      PH_NS_G: begin R_ns = 1'b0; G_ns = 1'b1; end
      PH_NS_Y: begin R_ns = 1'b0; Y_ns = 1'b1; end
      PH_EW_G: begin R_ew = 1'b0; G_ew = 1'b1; end
      PH_EW_Y: begin R_ew = 1'b0; Y_ew = 1'b1; end
      default: ;
    endcase
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl; exercises the walk feature when
// INTERSECTION_PED_WALK_EN is defined (built with WALK_LEN=9).
module tb_intersection_ctrl;

  logic clk = 1'b0;
  logic rst, tick, car_ns, car_ew, ped_ns, ped_ew, preempt;
  logic R_ns, Y_ns, G_ns, R_ew, Y_ew, G_ew;
  logic [2:0] phase;
`ifdef INTERSECTION_PED_WALK_EN
  logic walk_ns, walk_ew;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  intersection_ctrl #(.WALK_LEN(9)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .car_ns  (car_ns),
    .car_ew  (car_ew),
    .ped_ns  (ped_ns),
    .ped_ew  (ped_ew),
    .preempt (preempt),
    .R_ns    (R_ns),
    .Y_ns    (Y_ns),
    .G_ns    (G_ns),
    .R_ew    (R_ew),
    .Y_ew    (Y_ew),
    .G_ew    (G_ew),
`ifdef INTERSECTION_PED_WALK_EN
    .walk_ns (walk_ns),
    .walk_ew (walk_ew),
`endif
    .phase   (phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic lamps(input string tag, input logic [5:0] exp_l);
    check(tag, {R_ns, Y_ns, G_ns, R_ew, Y_ew, G_ew}, exp_l);
  endtask

  initial begin
    #200000;
    total++;
    $error("FAIL watchdog observed=timeout expected=finish");
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; car_ns = 1'b0; car_ew = 1'b0;
    ped_ns = 1'b0; ped_ew = 1'b0; preempt = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    check("rst_phase", phase, 0);
    check("rst_cnt", dut.cnt, 0);
    lamps("rst_lamps", 6'b001_100);
    check("rst_lat_ns", dut.ped_ns_lat_q, 0);
    check("rst_lat_ew", dut.ped_ew_lat_q, 0);

    // No demand: rest in NS_G, counter saturates at 63
    ticks(40);
    check("idle40_phase", phase, 0);
    check("idle40_cnt", dut.cnt, 40);
    lamps("idle40_lamps", 6'b001_100);
    ticks(30);
    check("idle70_cnt_sat", dut.cnt, 63);
    check("idle70_phase", phase, 0);

    // car_ew from reset: 10 + 5 + 2 ticks to EW_G
    rst = 1'b1; cyc(); rst = 1'b0;
    car_ew = 1'b1;
    ticks(9);
    check("cew_t9_phase", phase, 0);
    check("cew_t9_cnt", dut.cnt, 9);
    ticks(1);
    check("cew_t10_phase", phase, 1);
    check("cew_t10_cnt", dut.cnt, 0);
    lamps("cew_nsy_lamps", 6'b010_100);
    ticks(4);
    check("cew_t14_phase", phase, 1);
    ticks(1);
    check("cew_t15_phase", phase, 2);
    lamps("cew_ar1_lamps", 6'b100_100);
    ticks(1);
    check("cew_t16_phase", phase, 2);
    ticks(1);
    check("cew_t17_phase", phase, 3);
    lamps("cew_ewg_lamps", 6'b100_001);

    // ped_ns during EW_G with car_ew held
    ped_ns = 1'b1; cyc(); ped_ns = 1'b0;
    check("pns_lat_set", dut.ped_ns_lat_q, 1);
    check("pns_cnt_hold", dut.cnt, 0);
    ticks(9);
    check("pns_t9_phase", phase, 3);
    ticks(1);
    check("pns_t10_phase", phase, 4);
    lamps("pns_ewy_lamps", 6'b100_010);
    ticks(6);
    check("pns_ar2_phase", phase, 5);
    tick = 1'b1; ped_ns = 1'b1; cyc(); tick = 1'b0; ped_ns = 1'b0;
    check("pns_entry_phase", phase, 0);
    check("pns_set_wins", dut.ped_ns_lat_q, 1);
    // full cycle back to NS_G; latch is the only NS demand
    ticks(33);
    check("pns_loop_phase", phase, 5);
    check("pns_loop_lat", dut.ped_ns_lat_q, 1);
    ticks(1);
    check("pns_loop_entry", phase, 0);
    check("pns_lat_clr", dut.ped_ns_lat_q, 0);

    // Preempt at NS_G cnt=3
    car_ew = 1'b0;
    ticks(3);
    check("pre_cnt3", dut.cnt, 3);
    preempt = 1'b1; cyc();
    check("pre_to_nsy", phase, 1);
    check("pre_nsy_cnt", dut.cnt, 0);
    ticks(4);
    check("pre_nsy_hold", phase, 1);
    ticks(1);
    check("pre_enter", phase, 6);
    ticks(20);
    check("pre_hold_phase", phase, 6);
    lamps("pre_hold_lamps", 6'b100_100);
    preempt = 1'b0; cyc();
    check("pre_rel_ar2", phase, 5);
    ticks(1);
    check("pre_ar2_t1", phase, 5);
    ticks(1);
    check("pre_back_nsg", phase, 0);
    lamps("pre_back_lamps", 6'b001_100);

    // Preempt during all-red jumps straight to PRE
    car_ew = 1'b1;
    ticks(15);
    check("pre_ar1_phase", phase, 2);
    preempt = 1'b1; cyc();
    check("pre_from_ar1", phase, 6);
    preempt = 1'b0; cyc();
    check("pre_ar1_rel", phase, 5);
    ticks(2);
    check("pre_ar1_nsg", phase, 0);

    // Reset mid EW_Y
    ticks(17);
    check("rmid_ewg", phase, 3);
    car_ns = 1'b1;
    ticks(12);
    check("rmid_ewy", phase, 4);
    ped_ew = 1'b1; cyc(); ped_ew = 1'b0;
    check("rmid_lat_ew", dut.ped_ew_lat_q, 1);
    rst = 1'b1; tick = 1'b1; preempt = 1'b1; cyc();
    rst = 1'b0; tick = 1'b0; preempt = 1'b0;
    check("rmid_phase", phase, 0);
    check("rmid_cnt", dut.cnt, 0);
    check("rmid_lat_ew0", dut.ped_ew_lat_q, 0);
    lamps("rmid_lamps", 6'b001_100);
    car_ns = 1'b0;

`ifdef INTERSECTION_PED_WALK_EN
    // Walk served on NS_G entry; green held 12 ticks despite car_ew
    car_ew = 1'b1;
    ped_ns = 1'b1; cyc(); ped_ns = 1'b0;
    ticks(17);
    check("walk_ewg", phase, 3);
    ticks(17);
    check("walk_nsg", phase, 0);
    check("walk_on0", walk_ns, 1);
    check("walk_ew_off", walk_ew, 0);
    ticks(8);
    check("walk_on8", walk_ns, 1);
    ticks(1);
    check("walk_off9", walk_ns, 0);
    ticks(2);
    check("walk_hold11", phase, 0);
    ticks(1);
    check("walk_exit12", phase, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
